time_entry: RTL
===============

# time_entry

Keypad time-entry stage for the countdown timer. It accepts BCD digits one at a time into a 3-digit buffer: minutes, seconds tens, seconds ones. On start it normalizes seconds of 60 or more into minutes. It then drives the parallel `data` inputs and the active-low `loadn` of the downstream minute, seconds-tens and seconds-ones counter chain. It sits directly upstream of the counter chain, and its digit outputs are wired straight to the counters' `data` ports.

## Interface
- no parameters; digit widths fixed at 4-bit BCD
- `clock` in 1: single clock, all state on rising edge
- `clear` in 1: reset, asynchronous, active-high
- `key_valid` in 1: one-cycle strobe, `key_digit` valid
- `key_digit` in 4: BCD digit; values 10–15 ignored
- `entry_clr` in 1: synchronous cancel; empties buffer
- `start` in 1: request to load buffer into timer
- `timer_busy` in 1: high while downstream chain is counting
- `min_digit` out 4: buffer minutes digit (counter `data`)
- `sec_tens` out 4: buffer seconds-tens digit (counter `data`)
- `sec_ones` out 4: buffer seconds-ones digit (counter `data`)
- `loadn` out 1: active-low load pulse to all counters, registered
- `ready` out 1: high when in IDLE
- `entry_zero` out 1: high when buffer equals 0:00

## Operation
- States: IDLE, NORM, LOAD. State register is one-hot or binary. `loadn` = 0 only in LOAD. `ready` = 1 only in IDLE.
- Key entry (IDLE only, `key_valid`=1, `key_digit`≤9):
  - shift left: `min_digit`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`
  - the old minutes digit is discarded
- Keys in NORM or LOAD are dropped.
- Priority in IDLE, highest first: `entry_clr`, then `start`, then key. On simultaneous `start` and key, the key is dropped.
- `entry_clr` in IDLE: buffer ← 0:00.
- `start` in IDLE goes to NORM only if `timer_busy`=0 and `entry_zero`=0. Otherwise it is ignored and the buffer is unchanged.
- NORM, single cycle, at most one correction since `sec_tens`≤9:
  - if `sec_tens`≥6 and `min_digit`<9: `sec_tens`←`sec_tens`−6, `min_digit`←`min_digit`+1
  - if `sec_tens`≥6 and `min_digit`=9: clamp to 9:59
  - otherwise hold
  - next state is LOAD
- LOAD, single cycle: buffer held stable while `loadn`=0. Next state is IDLE, with buffer ← 0:00 on the same edge.
- `entry_clr` in NORM or LOAD aborts: next state IDLE, buffer ← 0:00, no further `loadn` pulse.
- `clear` asserted at any time: immediately state IDLE, all digits 0, `loadn`=1. This holds mid-NORM and mid-LOAD.
- Reset values: `min_digit`=`sec_tens`=`sec_ones`=0, `loadn`=1, `ready`=1, `entry_zero`=1.

## Timing
- Key accepted at edge k: digits updated after edge k.
- `start` sampled at edge k → NORM after edge k → LOAD after edge k+1, so `loadn`=0 from edge k+1 to edge k+2.
- The counters sample normalized data at edge k+2. After edge k+2: IDLE, buffer 0:00.
- `loadn` low width is exactly one clock period and glitch-free, because it is decoded from registered state only.
- Digit outputs are stable throughout the LOAD cycle.
- `ready` drops the cycle after `start` is accepted and returns after edge k+2.
- `timer_busy` is sampled only in IDLE together with `start`.

## Configuration
- `TIME_ENTRY_NORM_EN` defined:
  - NORM state and the seconds normalization/clamp are present
  - start-to-`loadn` latency is 1 cycle, with `loadn` low from edge k+1 to k+2
- `TIME_ENTRY_NORM_EN` undefined:
  - NORM state removed; `start` at edge k → LOAD directly, `loadn` low from edge k to k+1
  - raw digits are passed unmodified, e.g. 0:90 loads as 0:90
  - all other behaviour is identical

## Test plan
- Keys 1,3,0 then `start` → LOAD shows 1:30; `loadn` low exactly one cycle, edge k+1 to k+2 (macro on); buffer 0:00 and `ready`=1 afterwards.
- Keys 9,0 (0:90), `start` → 1:30 during LOAD. Keys 9,9,9, `start` → 9:59 with macro on, 9:99 with macro off (`loadn` at edge k).
- Keys 1,2,3,4 → buffer 2:34, leading 1 discarded. Key 12 then key 5 → 3:45, invalid code ignored.
- `start` with buffer 0:00, or with `timer_busy`=1 and buffer 0:45 → `loadn` stays 1, `ready` stays 1, buffer unchanged.
- `start` with `key_valid`=1 (`key_digit`=7) on the same edge, buffer 0:12 → load of 0:12, the 7 is not shifted in. `entry_clr` with `start` on the same edge → buffer 0:00, no load.
- Buffer 0:75, `start`, then `clear` pulsed mid-NORM → outputs 0:00, `loadn`=1, `ready`=1 immediately, before the next clock edge. `entry_clr` during LOAD → no second pulse, IDLE next cycle.

Source files
------------

// File: rtl/time_entry.sv
// time_entry: keypad time-entry stage feeding the minute / seconds-tens /
// seconds-ones counter chain. Digits shift in from the right. On start the
// buffer is normalized (seconds >= 60 carried into minutes, clamped at 9:59)
// and presented on the counters' data inputs while loadn pulses low for
// exactly one clock.
// Optional feature macro: TIME_ENTRY_NORM_EN (defined = NORM state and
// seconds normalization present; undefined = raw digits loaded directly).
module time_entry (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       entry_clr,
    input  logic       start,
    input  logic       timer_busy,
    output logic [3:0] min_digit,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       ready,
    output logic       entry_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef TIME_ENTRY_NORM_EN
        S_NORM = 2'd1,
`endif
        S_LOAD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] min_q,   min_d;
    logic [3:0] tens_q,  tens_d;
    logic [3:0] ones_q,  ones_d;
    logic       loadn_q, loadn_d;
    logic       ready_q, ready_d;

    // Buffer empty means 0:00; blocks a start that would load nothing.
    assign entry_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

    // Next-state, buffer and output decode for the entry FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        case (state_q)
            S_IDLE: begin
                if (entry_clr) begin
                    min_d  = 4'd0;
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                end else if (start) begin
                    // A start that is refused leaves the buffer untouched and
                    // still swallows any key on the same edge.
                    if (!timer_busy && !entry_zero) begin
`ifdef TIME_ENTRY_NORM_EN
                        state_d = S_NORM;
`else
                        state_d = S_LOAD;
`endif
                    end
                end else if (key_valid && (key_digit <= 4'd9)) begin
                    min_d  = tens_q;
                    tens_d = ones_q;
                    ones_d = key_digit;
                end
            end
`ifdef TIME_ENTRY_NORM_EN
            S_NORM: begin
                if (entry_clr) begin
                    state_d = S_IDLE;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else begin
                    state_d = S_LOAD;
                    // Seconds tens is at most 9, so one carry always suffices.
                    if (tens_q >= 4'd6) begin
                        if (min_q < 4'd9) begin
                            tens_d = tens_q - 4'd6;
                            min_d  = min_q + 4'd1;
                        end else begin
                            min_d  = 4'd9;
                            tens_d = 4'd5;
                            ones_d = 4'd9;
                        end
                    end
                end
            end
`endif
            S_LOAD: begin
                // Counters sample on this edge; buffer empties behind them.
                // An entry_clr here has the same effect.
                state_d = S_IDLE;
                min_d   = 4'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                min_d   = 4'd0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so loadn
        // and ready come straight off flops and cannot glitch.
        loadn_d = (state_d != S_LOAD);
        ready_d = (state_d == S_IDLE);
    end

    // State, buffer and registered outputs; clear forces IDLE at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            loadn_q <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            loadn_q <= loadn_d;
            ready_q <= ready_d;
        end
    end

    assign min_digit = min_q;
    assign sec_tens  = tens_q;
    assign sec_ones  = ones_q;
    assign loadn     = loadn_q;
    assign ready     = ready_q;

endmodule
